dma_ctrl: RTL and testbench

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl_if.sv | 26 ++
 rtl/dma_ctrl.sv | 148 ++++++++++++++
 tb/tb_dma_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ctrl_if.sv
// Bus bundle for dma_ctrl: CPU register port plus the DMA master port.
// slave is the DMA controller's view, master is the system/CPU side.
interface dma_ctrl_if;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rdy;
  logic        bus_own;
  logic [15:0] m_addr;
  logic [7:0]  m_dout;
  logic        m_we;
  logic [7:0]  m_din;
  logic        irq;

  modport slave (
    input  cs, we, addr, din, m_din,
    output dout, rdy, bus_own, m_addr, m_dout, m_we, irq
  );

  modport master (
    output cs, we, addr, din, m_din,
    input  dout, rdy, bus_own, m_addr, m_dout, m_we, irq
  );
endinterface

// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory DMA with copy and fill modes.
// Copy moves one byte per RD/WR pair, fill writes one byte per clock.
module dma_ctrl (
  input  logic      clk,
  input  logic      rst,
  dma_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StArm, StRd, StWr, StFin} state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, maddr_q, maddr_d;
  logic [7:0]  fill_q, fill_d, dout_q, dout_d;
  logic        ie_q, ie_d, fmode_q, fmode_d, sfix_q, sfix_d;
  logic        done_q, done_d, irq_q, irq_d, own_q, own_d, mwe_q, mwe_d;
  logic        busy, wr_en, rd_en, stat_rd, start;
  logic [7:0]  stat;

  always_comb begin
    busy    = (state_q != StIdle);
    wr_en   = bus.cs & bus.we & ~busy;
    rd_en   = bus.cs & ~bus.we;
    stat_rd = rd_en & (bus.addr == 3'd6);
    start   = wr_en & (bus.addr == 3'd6) & bus.din[0];
    stat    = {busy, done_q, 3'b000, fmode_q, ie_q, 1'b0};

    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    ie_d    = ie_q;
    fmode_d = fmode_q;
    sfix_d  = sfix_q;
    done_d  = done_q;
    irq_d   = irq_q;
    dout_d  = dout_q;

    if (wr_en) begin
      case (bus.addr)
        3'd0: src_d[7:0]  = bus.din;
        3'd1: src_d[15:8] = bus.din;
        3'd2: dst_d[7:0]  = bus.din;
        3'd3: dst_d[15:8] = bus.din;
        3'd4: len_d[7:0]  = bus.din;
        3'd5: len_d[15:8] = bus.din;
        3'd6: begin
          ie_d    = bus.din[1];
          fmode_d = bus.din[2];
          sfix_d  = bus.din[3];
        end
        3'd7: fill_d = bus.din;
      endcase
    end

    if (start || stat_rd) begin
      done_d = 1'b0;
      irq_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: if (start) state_d = (len_q != 16'h0000) ? StArm : StFin;
      StArm:  state_d = fmode_q ? StWr : StRd;
      StRd:   state_d = StWr;
      StWr: begin
        dst_d = dst_q + 16'h0001;
        if (!(sfix_q || fmode_q)) src_d = src_q + 16'h0001;
        len_d = len_q - 16'h0001;
        if (len_q == 16'h0001) state_d = StFin;
        else                   state_d = fmode_q ? StWr : StRd;
      end
      StFin: begin
        // Completion is evaluated last so it wins over a same-cycle STAT read.
        state_d = StIdle;
        done_d  = 1'b1;
        irq_d   = ie_q;
      end
      default: state_d = StIdle;
    endcase

    // Zero-length jobs go IDLE->FIN and never take the bus.
    if (state_d == StArm)       own_d = 1'b1;
    else if (state_d == StIdle) own_d = 1'b0;
    else                        own_d = own_q;

    mwe_d = (state_d == StWr);
    if (state_d == StRd)      maddr_d = src_d;
    else if (state_d == StWr) maddr_d = dst_d;
    else                      maddr_d = maddr_q;

    if (rd_en) begin
      case (bus.addr)
        3'd0: dout_d = src_q[7:0];
        3'd1: dout_d = src_q[15:8];
        3'd2: dout_d = dst_q[7:0];
        3'd3: dout_d = dst_q[15:8];
        3'd4: dout_d = len_q[7:0];
        3'd5: dout_d = len_q[15:8];
        3'd6: dout_d = stat;
        3'd7: dout_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      len_q   <= 16'h0000;
      maddr_q <= 16'h0000;
      fill_q  <= 8'h00;
      dout_q  <= 8'h00;
      ie_q    <= 1'b0;
      fmode_q <= 1'b0;
      sfix_q  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
      own_q   <= 1'b0;
      mwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      maddr_q <= maddr_d;
      fill_q  <= fill_d;
      dout_q  <= dout_d;
      ie_q    <= ie_d;
      fmode_q <= fmode_d;
      sfix_q  <= sfix_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
      own_q   <= own_d;
      mwe_q   <= mwe_d;
    end
  end

  // Read data from the synchronous memory arrives in WR, so copy data passes straight through.
  assign bus.m_dout  = (state_q != StWr) ? 8'h00 : (fmode_q ? fill_q : bus.m_din);
  assign bus.dout    = dout_q;
  assign bus.rdy     = ~own_q;
  assign bus.bus_own = own_q;
  assign bus.m_addr  = maddr_q;
  assign bus.m_we    = mwe_q;
  assign bus.irq     = irq_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Randomised self-checking bench for dma_ctrl with a synchronous memory model
// and a sequential byte-transfer reference model.
module tb_dma_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  dma_ctrl_if bus_if ();
  dma_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit   [7:0]  mem     [65536];
  bit          mem_vld [65536];
  bit   [7:0]  ref_mem [65536];
  bit          ref_vld [65536];
  logic [15:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  logic [15:0] rd_a_q[$];
  int          rdy_low_cnt = 0;
  int          we_viol     = 0;
  logic [15:0] prev_addr   = 16'h0000;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_vld[a] ? ref_mem[a] : init_byte(a);
  endfunction

  // System memory: reads return data one clock after the address.
  always @(posedge clk) begin
    if (bus_if.m_we && !bus_if.bus_own) we_viol <= we_viol + 1;
    if (bus_if.bus_own && bus_if.m_we) begin
      mem[bus_if.m_addr]     <= bus_if.m_dout;
      mem_vld[bus_if.m_addr] <= 1'b1;
      wr_a_q.push_back(bus_if.m_addr);
      wr_d_q.push_back(bus_if.m_dout);
      rd_a_q.push_back(prev_addr);
    end
    if (!bus_if.rdy) rdy_low_cnt <= rdy_low_cnt + 1;
    bus_if.m_din <= mem_vld[bus_if.m_addr] ? mem[bus_if.m_addr] : init_byte(bus_if.m_addr);
    prev_addr    <= bus_if.m_addr;
  end

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.din = d;
    @(posedge clk); #1;
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
    bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
    @(posedge clk); #1;
    bus_if.cs = 1'b0;
    d = bus_if.dout;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus_if.bus_own === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                          input logic [7:0] f);
    cpu_wr(3'd0, s[7:0]); cpu_wr(3'd1, s[15:8]);
    cpu_wr(3'd2, d[7:0]); cpu_wr(3'd3, d[15:8]);
    cpu_wr(3'd4, n[7:0]); cpu_wr(3'd5, n[15:8]);
    cpu_wr(3'd7, f);
  endtask

  // Full transfer scenario: program, start, then check writes, reads, timing and registers.
  task automatic run_xfer(input string nm, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input logic [7:0] f, input logic [7:0] ctrl,
                          input bit poke);
    logic [15:0] ea[$], er[$];
    logic [7:0]  ed[$];
    logic [15:0] sa, da, exp_src;
    logic [7:0]  lo, hi, st, exp_st, v;
    bit          fm, fx, ok;
    int          nw0, rl0, got_n, exp_cyc;
    fm = ctrl[2]; fx = ctrl[3];
    set_regs(s, d, n, f);
    for (int i = 0; i < int'(n); i++) begin
      sa = (fm || fx) ? s : s + 16'(i);
      da = d + 16'(i);
      v  = fm ? f : ref_rd(sa);
      ref_mem[da] = v; ref_vld[da] = 1'b1;
      ea.push_back(da); ed.push_back(v); er.push_back(sa);
    end
    nw0 = wr_a_q.size(); rl0 = rdy_low_cnt;
    cpu_wr(3'd6, ctrl);
    if (poke) begin
      cpu_wr(3'd2, 8'h55);
      cpu_wr(3'd3, 8'h66);
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s timeout: bus_own=%b want 0", nm, bus_if.bus_own); end
    got_n = wr_a_q.size() - nw0;
    total++;
    if (got_n != int'(n)) begin
      bad++; $display("FAIL %s write count: got %0d want %0d", nm, got_n, n);
    end
    for (int i = 0; i < int'(n) && i < got_n; i++) begin
      total++;
      if (wr_a_q[nw0+i] !== ea[i] || wr_d_q[nw0+i] !== ed[i]) begin
        bad++; $display("FAIL %s write %0d: got %h=%h want %h=%h", nm, i,
                        wr_a_q[nw0+i], wr_d_q[nw0+i], ea[i], ed[i]);
      end
      if (!fm) begin
        total++;
        if (rd_a_q[nw0+i] !== er[i]) begin
          bad++; $display("FAIL %s read addr %0d: got %h want %h", nm, i, rd_a_q[nw0+i], er[i]);
        end
      end
    end
    exp_cyc = fm ? int'(n) + 2 : 2 * int'(n) + 2;
    total++;
    if (rdy_low_cnt - rl0 != exp_cyc) begin
      bad++; $display("FAIL %s rdy low clks: got %0d want %0d", nm, rdy_low_cnt - rl0, exp_cyc);
    end
    total++;
    if (bus_if.irq !== ctrl[1]) begin
      bad++; $display("FAIL %s irq: got %b want %b", nm, bus_if.irq, ctrl[1]);
    end
    exp_src = (fm || fx) ? s : s + n;
    cpu_rd(3'd0, lo); cpu_rd(3'd1, hi);
    total++;
    if ({hi, lo} !== exp_src) begin
      bad++; $display("FAIL %s SRC: got %h want %h", nm, {hi, lo}, exp_src);
    end
    cpu_rd(3'd2, lo); cpu_rd(3'd3, hi);
    total++;
    if ({hi, lo} !== 16'(d + n)) begin
      bad++; $display("FAIL %s DST: got %h want %h", nm, {hi, lo}, 16'(d + n));
    end
    cpu_rd(3'd4, lo); cpu_rd(3'd5, hi);
    total++;
    if ({hi, lo} !== 16'h0000) begin
      bad++; $display("FAIL %s LEN: got %h want 0000", nm, {hi, lo});
    end
    exp_st = {2'b01, 3'b000, fm, ctrl[1], 1'b0};
    cpu_rd(3'd6, st);
    total++;
    if (st !== exp_st) begin bad++; $display("FAIL %s STAT: got %h want %h", nm, st, exp_st); end
    exp_st = {2'b00, 3'b000, fm, ctrl[1], 1'b0};
    cpu_rd(3'd6, st);
    total++;
    if (st !== exp_st || bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL %s STAT after read: got %h irq=%b want %h irq=0", nm, st,
                      bus_if.irq, exp_st);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    #1 rst = 1'b0;
    #1;
    total++;
    if (bus_if.rdy !== 1'b1 || bus_if.bus_own !== 1'b0 || bus_if.m_we !== 1'b0 ||
        bus_if.irq !== 1'b0 || bus_if.dout !== 8'h00 || bus_if.m_addr !== 16'h0000 ||
        bus_if.m_dout !== 8'h00) begin
      bad++; $display("FAIL reset outputs: got rdy=%b own=%b we=%b irq=%b dout=%h ma=%h md=%h",
                      bus_if.rdy, bus_if.bus_own, bus_if.m_we, bus_if.irq, bus_if.dout,
                      bus_if.m_addr, bus_if.m_dout);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      cpu_rd(3'(a), v);
      total++;
      if (v !== 8'h00) begin bad++; $display("FAIL reset reg %0d: got %h want 00", a, v); end
    end
  endtask

  task automatic test_copy();
    run_xfer("copy", 16'h0100, 16'h0200, 16'h0004, 8'h00, 8'h03, 1'b0);
  endtask

  task automatic test_fill();
    run_xfer("fill", 16'h1234, 16'h7FFE, 16'h0004, 8'hA5, 8'h05, 1'b0);
  endtask

  task automatic test_wrap();
    run_xfer("wrap", 16'hFFFF, 16'hFFFE, 16'h0003, 8'h00, 8'h01, 1'b0);
  endtask

  task automatic test_ignore_busy();
    run_xfer("busy_wr", 16'h4000, 16'h4100, 16'h0004, 8'h00, 8'h03, 1'b1);
  endtask

  task automatic test_zero_len();
    logic [7:0] st;
    int nw0, rl0;
    set_regs(16'h2000, 16'h2100, 16'h0000, 8'h11);
    nw0 = wr_a_q.size(); rl0 = rdy_low_cnt;
    cpu_wr(3'd6, 8'h03);
    total++;
    if (bus_if.rdy !== 1'b1 || bus_if.bus_own !== 1'b0) begin
      bad++; $display("FAIL zero rdy/own: got %b/%b want 1/0", bus_if.rdy, bus_if.bus_own);
    end
    @(posedge clk); #1;
    total++;
    if (bus_if.irq !== 1'b1) begin bad++; $display("FAIL zero irq: got %b want 1", bus_if.irq); end
    cpu_wr(3'd6, 8'h03);
    total++;
    if (bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL start clears irq: got %b want 0", bus_if.irq);
    end
    @(posedge clk); #1;
    cpu_rd(3'd6, st);
    total++;
    if (st !== 8'h42) begin bad++; $display("FAIL zero STAT: got %h want 42", st); end
    cpu_rd(3'd6, st);
    total++;
    if (st !== 8'h02) begin bad++; $display("FAIL zero STAT after: got %h want 02", st); end
    total++;
    if (wr_a_q.size() != nw0 || rdy_low_cnt != rl0) begin
      bad++; $display("FAIL zero bus use: got writes=%0d rdylow=%0d want 0/0",
                      wr_a_q.size() - nw0, rdy_low_cnt - rl0);
    end
  endtask

  task automatic test_race();
    logic [7:0] st, v;
    bit ok;
    int nw0;
    set_regs(16'h5000, 16'h5100, 16'h0001, 8'h00);
    v = ref_rd(16'h5000);
    ref_mem[16'h5100] = v; ref_vld[16'h5100] = 1'b1;
    nw0 = wr_a_q.size();
    cpu_wr(3'd6, 8'h03);
    repeat (3) begin @(posedge clk); #1; end
    cpu_rd(3'd6, st);
    total++;
    if (st !== 8'h82 || bus_if.irq !== 1'b1) begin
      bad++; $display("FAIL race STAT in FIN: got %h irq=%b want 82 irq=1", st, bus_if.irq);
    end
    cpu_rd(3'd6, st);
    total++;
    if (st !== 8'h42) begin bad++; $display("FAIL race STAT: got %h want 42", st); end
    wait_idle(ok);
    total++;
    if (wr_a_q.size() != nw0 + 1 || wr_d_q[nw0] !== v) begin
      bad++; $display("FAIL race write: got n=%0d want n=1 data %h", wr_a_q.size() - nw0, v);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] st, v;
    int nw0, n;
    set_regs(16'h3000, 16'h3100, 16'h0008, 8'h00);
    nw0 = wr_a_q.size();
    cpu_wr(3'd6, 8'h03);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (wr_a_q.size() > nw0) break;
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    total++;
    if (bus_if.rdy !== 1'b1 || bus_if.bus_own !== 1'b0 || bus_if.m_we !== 1'b0) begin
      bad++; $display("FAIL abort async: got rdy=%b own=%b we=%b want 1/0/0",
                      bus_if.rdy, bus_if.bus_own, bus_if.m_we);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    n = wr_a_q.size() - nw0;
    total++;
    if (n < 1 || n > 2) begin bad++; $display("FAIL abort writes: got %0d want 1..2", n); end
    for (int i = 0; i < n; i++) begin
      v = ref_rd(16'h3000 + 16'(i));
      ref_mem[16'h3100 + 16'(i)] = v; ref_vld[16'h3100 + 16'(i)] = 1'b1;
      total++;
      if (wr_a_q[nw0+i] !== 16'h3100 + 16'(i) || wr_d_q[nw0+i] !== v) begin
        bad++; $display("FAIL abort byte %0d: got %h=%h want %h=%h", i, wr_a_q[nw0+i],
                        wr_d_q[nw0+i], 16'h3100 + 16'(i), v);
      end
    end
    @(posedge clk); #1;
    cpu_rd(3'd6, st);
    total++;
    if (st !== 8'h00) begin bad++; $display("FAIL abort STAT: got %h want 00", st); end
    repeat (6) begin @(posedge clk); #1; end
    total++;
    if (bus_if.bus_own !== 1'b0 || wr_a_q.size() != nw0 + n) begin
      bad++; $display("FAIL abort restart: got own=%b writes=%0d want 0/%0d",
                      bus_if.bus_own, wr_a_q.size() - nw0, n);
    end
  endtask

  task automatic test_random();
    logic [15:0] s, d, n;
    logic [7:0]  f, ctrl;
    for (int k = 0; k < 8; k++) begin
      s    = 16'($urandom);
      d    = 16'($urandom);
      n    = 16'($urandom_range(1, 12));
      f    = 8'($urandom);
      ctrl = {4'b0000, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1};
      run_xfer("random", s, d, n, f, ctrl, 1'b0);
    end
    total++;
    if (we_viol != 0) begin bad++; $display("FAIL m_we without bus_own: got %0d want 0", we_viol); end
  endtask

  initial begin
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = 3'd0; bus_if.din = 8'h00;
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_zero_len();
    test_race();
    test_ignore_busy();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
